// File: rtl/lane_render_pkg.sv
// Shared types and code-decode helpers for the lane erase/redraw engine.
// Pure definitions: no latency, no flow control.
package lane_render_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PLOT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int CODE_W = 3;
  localparam logic [2:0] ERASE_COLOUR = 3'b000;

  // Codes 1..4 select a segment; everything else draws nothing.
  function automatic logic code_valid(input logic [CODE_W-1:0] code);
    return (code >= 3'd1) && (code <= 3'd4);
  endfunction

  function automatic logic [8:0] code_to_xstart(input logic [CODE_W-1:0] code,
                                                input int x_base, input int seg_w);
    int xs;
    xs = x_base + (int'(code) - 1) * seg_w;
    return 9'(xs);
  endfunction

endpackage

// File: rtl/rect_scanner.sv
// Row-major rectangle walker: load sets the first pixel, each step advances one pixel.
// Position is visible the cycle after load/step; no backpressure beyond step_i.
module rect_scanner (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [8:0] x_start_i,
  input  logic [8:0] width_i,
  input  logic [7:0] y0_i,
  input  logic [7:0] height_i,
  output logic [8:0] x_o,
  output logic [7:0] y_o,
  output logic       last_o
);

  logic [8:0] xs_q, w_q, col_q, x_q;
  logic [7:0] h_q, row_q, y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs_q  <= '0;
      w_q   <= '0;
      h_q   <= '0;
      col_q <= '0;
      row_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (load_i) begin
      xs_q  <= x_start_i;
      w_q   <= width_i;
      h_q   <= height_i;
      col_q <= '0;
      row_q <= '0;
      x_q   <= x_start_i;
      y_q   <= y0_i;
    end else if (step_i) begin
      if (col_q == w_q - 9'd1) begin
        // y wraps mod 256 by plain 8-bit overflow
        col_q <= '0;
        x_q   <= xs_q;
        row_q <= row_q + 8'd1;
        y_q   <= y_q + 8'd1;
      end else begin
        col_q <= col_q + 9'd1;
        x_q   <= x_q + 9'd1;
      end
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (col_q == w_q - 9'd1) && (row_q == h_q - 8'd1);

endmodule

// File: rtl/lane_frame_renderer.sv
// Per-frame erase-then-draw of one bar per lane, one pixel per cycle to the VGA adapter.
// First pixel two cycles after start; start is ignored until the engine is back in IDLE.
module lane_frame_renderer
  import lane_render_pkg::*;
#(
  parameter int         NUM_LANES   = 4,
  parameter int         LANE_PITCH  = 40,
  parameter int         BAR_H       = 4,
  parameter int         X_BASE      = 120,
  parameter int         SEG_W       = 20,
  parameter logic [2:0] DRAW_COLOUR = 3'b111
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [CODE_W*NUM_LANES-1:0]   lane_code,
  input  logic [5:0]                    offset,
  output logic [8:0]                    x_out,
  output logic [7:0]                    y_out,
  output logic [2:0]                    c_out,
  output logic                          writeEN,
  output logic                          busy,
  output logic                          all_done
);

  state_t state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic [CODE_W*NUM_LANES-1:0] work_code_q, shadow_code_q;
  logic [5:0] work_off_q, shadow_off_q;

  logic [2:0]        lane;
  logic              erase;
  logic              last_phase;
  logic [CODE_W-1:0] sel_code;
  logic [5:0]        sel_off;
  logic [7:0]        sel_y0;
  logic              sc_load, sc_step, sc_last;
  logic [8:0]        sc_x;
  logic [7:0]        sc_y;

  // Even phases erase the previous frame's bar, odd phases draw the new one.
  assign lane       = phase_q[3:1];
  assign erase      = ~phase_q[0];
  assign last_phase = (phase_q == 4'(2 * NUM_LANES - 1));

  always_comb begin
    sel_code = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane == 3'(i)) begin
        sel_code = erase ? shadow_code_q[CODE_W*i +: CODE_W] : work_code_q[CODE_W*i +: CODE_W];
      end
    end
    sel_off = erase ? shadow_off_q : work_off_q;
    sel_y0  = 8'(32'(lane) * LANE_PITCH) + {2'b00, sel_off};
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sc_load = 1'b0;
    sc_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          phase_d = '0;
        end
      end
      S_SETUP: begin
        if (code_valid(sel_code)) begin
          sc_load = 1'b1;
          state_d = S_PLOT;
        end else if (last_phase) begin
          state_d = S_DONE;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      S_PLOT: begin
        sc_step = 1'b1;
        if (sc_last) begin
          if (last_phase) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            phase_d = phase_q + 4'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      work_code_q   <= '0;
      work_off_q    <= '0;
      shadow_code_q <= '0;
      shadow_off_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      if (state_q == S_IDLE && start) begin
        work_code_q <= lane_code;
        work_off_q  <= offset;
      end
      if (state_q == S_DONE) begin
        shadow_code_q <= work_code_q;
        shadow_off_q  <= work_off_q;
      end
    end
  end

  rect_scanner u_scanner (
    .clk       (clk),
    .rst_n     (resetn),
    .load_i    (sc_load),
    .step_i    (sc_step),
    .x_start_i (code_to_xstart(sel_code, X_BASE, SEG_W)),
    .width_i   (9'(SEG_W)),
    .y0_i      (sel_y0),
    .height_i  (8'(BAR_H)),
    .x_o       (sc_x),
    .y_o       (sc_y),
    .last_o    (sc_last)
  );

  // Every output is a pure function of flops, so reset clears them at once.
  assign writeEN  = (state_q == S_PLOT);
  assign x_out    = writeEN ? sc_x : 9'd0;
  assign y_out    = writeEN ? sc_y : 8'd0;
  assign c_out    = writeEN ? (erase ? ERASE_COLOUR : DRAW_COLOUR) : 3'd0;
  assign busy     = (state_q != S_IDLE);
  assign all_done = (state_q == S_DONE);

endmodule

// File: tb/tb_lane_frame_renderer.sv
// Bench for lane_frame_renderer: two instances (lane pitch 40 and 64) against a pixel-list model.
module tb_lane_frame_renderer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [11:0] lane_code = '0;
  logic [5:0]  offset = '0;

  logic [8:0] x0, x1;
  logic [7:0] y0, y1;
  logic [2:0] c0, c1;
  logic       we0, we1, busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  lane_frame_renderer #(.NUM_LANES(4), .LANE_PITCH(40), .BAR_H(4), .X_BASE(120),
                        .SEG_W(20), .DRAW_COLOUR(3'b111)) dut0 (
    .clk(clk), .resetn(resetn), .start(start), .lane_code(lane_code), .offset(offset),
    .x_out(x0), .y_out(y0), .c_out(c0), .writeEN(we0), .busy(busy0), .all_done(done0));

  lane_frame_renderer #(.NUM_LANES(4), .LANE_PITCH(64), .BAR_H(4), .X_BASE(120),
                        .SEG_W(20), .DRAW_COLOUR(3'b111)) dut1 (
    .clk(clk), .resetn(resetn), .start(start), .lane_code(lane_code), .offset(offset),
    .x_out(x1), .y_out(y1), .c_out(c1), .writeEN(we1), .busy(busy1), .all_done(done1));

  typedef logic [19:0] pix_t;
  typedef pix_t pix_q_t[$];

  typedef struct {
    logic [11:0] codes;
    logic [5:0]  off;
    int          exp_cyc;
  } vec_t;

  pix_q_t exp0, exp1, got0, got1;
  logic [11:0] sh_codes = '0;
  logic [5:0]  sh_off = '0;
  int n_checks = 0;
  int n_pass = 0;

  // Expected pixel stream: walk lanes, erase (previous frame) then draw (this frame).
  function automatic pix_q_t model(input logic [11:0] codes, input logic [5:0] off,
                                   input logic [11:0] shc, input logic [5:0] sho,
                                   input int pitch);
    pix_q_t q;
    for (int ln = 0; ln < N; ln++) begin
      for (int ph = 0; ph < 2; ph++) begin
        int code;
        int o;
        code = (ph == 0) ? int'(shc[3*ln +: 3]) : int'(codes[3*ln +: 3]);
        o    = (ph == 0) ? int'(sho) : int'(off);
        if (code >= 1 && code <= 4) begin
          for (int r = 0; r < 4; r++) begin
            for (int xx = 0; xx < 20; xx++) begin
              q.push_back({9'(120 + (code - 1) * 20 + xx), 8'((ln * pitch + o + r) % 256),
                           (ph == 1) ? 3'b111 : 3'b000});
            end
          end
        end
      end
    end
    return q;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  task automatic chk_stream(input string name, input pix_q_t got, input pix_q_t exp);
    int bad;
    bad = -1;
    n_checks++;
    if (got.size() != exp.size()) begin
      $display("FAIL %s: got %0d pixels expected %0d", name, got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        if (bad < 0 && got[i] !== exp[i]) bad = i;
      end
      if (bad < 0) n_pass++;
      else $display("FAIL %s: pixel %0d got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d", name, bad,
                    got[bad][19:11], got[bad][10:3], got[bad][2:0],
                    exp[bad][19:11], exp[bad][10:3], exp[bad][2:0]);
    end
  endtask

  // Starts a frame at the next edge and collects both pixel streams until all_done.
  task automatic run_frame(input string tag, input logic [11:0] codes, input logic [5:0] off,
                           input int exp_cyc_in, input bit disturb);
    int done_at0, done_at1, exp_cyc;
    exp0 = model(codes, off, sh_codes, sh_off, 40);
    exp1 = model(codes, off, sh_codes, sh_off, 64);
    exp_cyc = (exp_cyc_in < 0) ? (2 * N + exp0.size() + 1) : exp_cyc_in;
    got0.delete();
    got1.delete();
    lane_code = codes;
    offset = off;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    done_at0 = 0;
    done_at1 = 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      if (we0) got0.push_back({x0, y0, c0});
      if (we1) got1.push_back({x1, y1, c1});
      if (done0 && done_at0 == 0) done_at0 = cyc;
      if (done1 && done_at1 == 0) done_at1 = cyc;
      if (disturb && cyc == 10) begin
        start = 1'b1;
        lane_code = 12'($urandom);
        offset = 6'($urandom);
      end
      if (disturb && cyc == 15) chk({tag, "_busy_hold"}, 32'(busy0), 32'd1);
      if (disturb && cyc == 20) start = 1'b0;
      if (done_at0 != 0 && done_at1 != 0) break;
      @(negedge clk);
    end
    chk({tag, "_done_cycle0"}, done_at0, exp_cyc);
    chk({tag, "_done_cycle1"}, done_at1, exp_cyc);
    chk_stream({tag, "_pixels0"}, got0, exp0);
    chk_stream({tag, "_pixels1"}, got1, exp1);
    sh_codes = codes;
    sh_off = off;
    @(negedge clk);
    chk({tag, "_idle_after"}, 32'(busy0), 32'd0);
  endtask

  vec_t vecs[4];

  initial begin
    // Lane codes packed {lane3, lane2, lane1, lane0}; cycle counts are 2N + pixels + 1.
    vecs[0] = '{codes: {3'd1, 3'd7, 3'd3, 3'd0}, off: 6'd0,  exp_cyc: 169};
    vecs[1] = '{codes: {3'd2, 3'd2, 3'd2, 3'd2}, off: 6'd63, exp_cyc: 489};
    vecs[2] = '{codes: {3'd4, 3'd0, 3'd6, 3'd5}, off: 6'd17, exp_cyc: 409};
    vecs[3] = '{codes: {3'd0, 3'd0, 3'd1, 3'd4}, off: 6'd1,  exp_cyc: 249};

    repeat (3) @(negedge clk);
    chk("rst_writeEN", 32'(we0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_all_done", 32'(done1), 32'd0);
    chk("rst_xyc", {x0, y0, c0}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy1), 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].codes, vecs[i].off, vecs[i].exp_cyc, 1'b0);
      if (i == 0) begin
        chk("lane1_first", got0[0], {9'd160, 8'd40, 3'd7});
        chk("lane3_first", got0[80], {9'd120, 8'd120, 3'd7});
        chk("lane3_last", got0[159], {9'd139, 8'd123, 3'd7});
      end
      if (i == 1) begin
        chk("wrap_row255", got1[got1.size() - 80], {9'd140, 8'd255, 3'd7});
        chk("wrap_row2_last", got1[got1.size() - 1], {9'd159, 8'd2, 3'd7});
      end
    end

    run_frame("disturb", {3'd3, 3'd4, 3'd1, 3'd2}, 6'd9, -1, 1'b1);
    run_frame("after_disturb", 12'($urandom), 6'($urandom), -1, 1'b0);

    // Reset in the middle of a PLOT burst.
    lane_code = {3'd1, 3'd1, 3'd1, 3'd1};
    offset = 6'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && !we0; k++) @(negedge clk);
    chk("reach_plot", 32'(we0), 32'd1);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_writeEN0", 32'(we0), 32'd0);
    chk("midrst_writeEN1", 32'(we1), 32'd0);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_x", 32'(x0), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    sh_codes = '0;
    sh_off = '0;
    @(negedge clk);
    run_frame("post_rst", {3'd1, 3'd1, 3'd1, 3'd1}, 6'd3, 329, 1'b0);

    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("rand%0d", i), 12'($urandom), 6'($urandom), -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
